// File: rtl/bn_pkg.sv
// Shared types and helpers for the batch-norm backward streaming unit.
// Configuration macro: BN_BWD_SAT_EN selects saturating results; when it is
// undefined, final results wrap to their low W bits.
package bn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC1,
    ST_CALC2,
    ST_EMIT
  } bnState_t;

  // Width of the scratch arithmetic used for full-precision products.
  localparam int MATH_W = 64;

  // Signed fixed-point operand width.
  function automatic int opWidth(input int il, input int fl);
    return il + fl;
  endfunction

  // Accumulator width for a sum of up to 'size' W-bit operands.
  function automatic int accWidth(input int w, input int size);
    return w + $clog2(size) + 1;
  endfunction

  // Width of a W x W product after dropping FL fraction bits.
  function automatic int prodWidth(input int w, input int fl);
    return 2 * w - fl;
  endfunction

  // round(2^fl / n); n <= 0 yields zero so an unused table slot stays benign.
  function automatic logic [31:0] recip(input int n, input int fl);
    longint numer;
    if (n <= 0) return '0;
    numer = (longint'(1) <<< fl) + longint'(n / 2);
    return 32'(numer / longint'(n));
  endfunction

  // Reduce a wide signed value to a w-bit result, sign-extended to MATH_W.
  function automatic logic signed [MATH_W-1:0] sat(input logic signed [MATH_W-1:0] v,
                                                   input int w);
`ifdef BN_BWD_SAT_EN
    logic signed [MATH_W-1:0] maxV;
    logic signed [MATH_W-1:0] minV;
    maxV = (64'sd1 <<< (w - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (w - 1));
    if (v > maxV) return maxV;
    if (v < minV) return minV;
    return v;
`else
    return (v <<< (MATH_W - w)) >>> (MATH_W - w);
`endif
  endfunction

endpackage

// File: rtl/bn_backward_stream_buf.sv
// Element store for one job: SIZE entries of {dY, xhat}, one synchronous
// write port and one combinational read port. Contents are not reset.
module bn_bwd_buf #(
  parameter int W    = 20,
  parameter int SIZE = 16
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [$clog2(SIZE)-1:0]   i_waddr,
  input  logic signed [W-1:0]       i_wdy,
  input  logic signed [W-1:0]       i_wxhat,
  input  logic [$clog2(SIZE)-1:0]   i_raddr,
  output logic signed [W-1:0]       o_rdy,
  output logic signed [W-1:0]       o_rxhat
);

  logic signed [W-1:0] r_dy   [SIZE];
  logic signed [W-1:0] r_xhat [SIZE];

  // Capture one element pair per accepted beat; stale data is overwritten by the next job.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_dy[i_waddr]   <= i_wdy;
      r_xhat[i_waddr] <= i_wxhat;
    end
  end

  assign o_rdy   = r_dy[i_raddr];
  assign o_rxhat = r_xhat[i_raddr];

endmodule

// File: rtl/bn_backward_stream.sv
// Streaming batch-norm backward unit: header, LOAD of (dY, xhat) pairs with
// running reductions, two scalar set-up cycles, then one dX per cycle.
// Configuration macro: BN_BWD_SAT_EN (saturating results; default wraps).
module bn_backward_stream
  import bn_pkg::*;
#(
  parameter int IL   = 4,
  parameter int FL   = 16,
  parameter int SIZE = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_hdr_valid,
  output logic                      o_hdr_ready,
  input  logic [$clog2(SIZE):0]     i_hdr_num,
  input  logic signed [IL+FL-1:0]   i_hdr_gamma,
  input  logic signed [IL+FL-1:0]   i_hdr_inv_std,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic signed [IL+FL-1:0]   i_in_dy,
  input  logic signed [IL+FL-1:0]   i_in_xhat,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [IL+FL-1:0]   o_out_dx,
  output logic                      o_out_last,
  output logic signed [IL+FL-1:0]   o_dgamma,
  output logic signed [IL+FL-1:0]   o_dbeta,
  output logic                      o_stat_valid,
  output logic                      o_err_num
);

  localparam int W  = opWidth(IL, FL);
  localparam int NW = $clog2(SIZE) + 1;
  localparam int AB = $clog2(SIZE);
  localparam int AW = accWidth(W, SIZE);
  localparam int PW = prodWidth(W, FL);
  // The dY*xhat reduction carries the product's extra integer bits so it cannot wrap.
  localparam int XW = PW + $clog2(SIZE) + 1;
  localparam int M  = MATH_W;

  bnState_t               r_state;
  bnState_t               w_nextState;
  logic [NW-1:0]          r_num;
  logic [NW-1:0]          r_cnt;
  logic [NW-1:0]          w_hdrNumClamped;
  logic signed [W-1:0]    r_gamma;
  logic signed [W-1:0]    r_invStd;
  logic signed [AW-1:0]   r_sumDy;
  logic signed [XW-1:0]   r_sumDyx;
  logic signed [PW-1:0]   r_k;
  logic signed [PW-1:0]   r_kn;
  logic signed [W-1:0]    r_dgamma;
  logic signed [W-1:0]    r_dbeta;
  logic                   r_errNum;
  logic [31:0]            w_recip;
  logic                   w_inFire;
  logic                   w_lastIn;
  logic                   w_lastOut;
  logic signed [W-1:0]    w_bufDy;
  logic signed [W-1:0]    w_bufXhat;
  logic signed [M-1:0]    w_centered;
  logic signed [M-1:0]    w_dxFull;

  assign w_hdrNumClamped = (i_hdr_num > NW'(SIZE)) ? NW'(SIZE) : i_hdr_num;
  assign w_inFire        = (r_state == ST_LOAD) && i_in_valid;
  assign w_lastIn        = w_inFire && (r_cnt == r_num - NW'(1));
  assign w_lastOut       = (r_cnt == r_num - NW'(1));

  bn_bwd_buf #(
    .W    (W),
    .SIZE (SIZE)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_inFire),
    .i_waddr (r_cnt[AB-1:0]),
    .i_wdy   (i_in_dy),
    .i_wxhat (i_in_xhat),
    .i_raddr (r_cnt[AB-1:0]),
    .o_rdy   (w_bufDy),
    .o_rxhat (w_bufXhat)
  );

  // Reciprocal lookup of the latched element count; each entry is a constant.
  always_comb begin
    w_recip = '0;
    for (int n = 1; n <= SIZE; n++) begin
      if (r_num == NW'(n)) w_recip = recip(n, FL);
    end
  end

  // dX for the element at the read index: kn * (N*dy - sum_dy - xhat*sum_dyx).
  always_comb begin
    w_centered = ($signed(M'(r_num)) * M'(w_bufDy)) - M'(r_sumDy)
               - ((M'(w_bufXhat) * M'(r_sumDyx)) >>> FL);
    w_dxFull   = (M'(r_kn) * w_centered) >>> FL;
  end

  assign o_out_dx     = (r_state == ST_EMIT) ? W'(sat(w_dxFull, W)) : '0;
  assign o_dgamma     = (r_state == ST_EMIT) ? r_dgamma : '0;
  assign o_dbeta      = (r_state == ST_EMIT) ? r_dbeta : '0;
  assign o_err_num    = r_errNum;

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_nextState  = r_state;
    o_hdr_ready  = 1'b0;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_stat_valid = 1'b0;
    o_out_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_hdr_ready = !reset;
        if (i_hdr_valid && (i_hdr_num != '0)) w_nextState = ST_LOAD;
      end
      ST_LOAD: begin
        o_in_ready = 1'b1;
        if (w_lastIn) w_nextState = ST_CALC1;
      end
      ST_CALC1: w_nextState = ST_CALC2;
      ST_CALC2: w_nextState = ST_EMIT;
      ST_EMIT: begin
        o_out_valid  = 1'b1;
        o_stat_valid = 1'b1;
        o_out_last   = w_lastOut;
        if (i_out_ready && w_lastOut) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: header latch, reductions, scalar set-up and the shared element index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num    <= '0;
      r_cnt    <= '0;
      r_gamma  <= '0;
      r_invStd <= '0;
      r_sumDy  <= '0;
      r_sumDyx <= '0;
      r_k      <= '0;
      r_kn     <= '0;
      r_dgamma <= '0;
      r_dbeta  <= '0;
      r_errNum <= 1'b0;
    end else begin
      r_errNum <= (r_state == ST_IDLE) && i_hdr_valid && (i_hdr_num == '0);
      case (r_state)
        ST_IDLE: begin
          if (i_hdr_valid) begin
            r_num    <= w_hdrNumClamped;
            r_gamma  <= i_hdr_gamma;
            r_invStd <= i_hdr_inv_std;
            r_sumDy  <= '0;
            r_sumDyx <= '0;
            r_cnt    <= '0;
          end
        end
        ST_LOAD: begin
          if (i_in_valid) begin
            r_sumDy  <= r_sumDy + AW'(i_in_dy);
            r_sumDyx <= r_sumDyx + XW'((M'(i_in_dy) * M'(i_in_xhat)) >>> FL);
            r_cnt    <= w_lastIn ? '0 : r_cnt + NW'(1);
          end
        end
        ST_CALC1: r_k <= PW'((M'(r_gamma) * M'(r_invStd)) >>> FL);
        ST_CALC2: begin
          r_kn     <= PW'((M'(r_k) * $signed(M'(w_recip))) >>> FL);
          r_dgamma <= W'(sat(M'(r_sumDyx), W));
          r_dbeta  <= W'(sat(M'(r_sumDy), W));
        end
        ST_EMIT: begin
          if (i_out_ready) r_cnt <= w_lastOut ? '0 : r_cnt + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_backward_stream.sv
// Directed bench for bn_backward_stream: table of whole jobs plus
// hand-written sequences for backpressure, bad headers and mid-job reset.
module tb_bn_backward_stream;

  localparam int IL   = 4;
  localparam int FL   = 16;
  localparam int SIZE = 16;
  localparam int W    = IL + FL;
  localparam int NW   = $clog2(SIZE) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          hdrValid;
  logic          hdrReady;
  logic [NW-1:0] hdrNum;
  logic [W-1:0]  hdrGamma;
  logic [W-1:0]  hdrInvStd;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inDy;
  logic [W-1:0]  inXhat;
  logic          outValid;
  logic          outReady;
  logic [W-1:0]  outDx;
  logic          outLast;
  logic [W-1:0]  dgamma;
  logic [W-1:0]  dbeta;
  logic          statValid;
  logic          errNum;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string                   name;
    int                      num;
    logic [W-1:0]            gamma;
    logic [W-1:0]            invStd;
    logic [SIZE-1:0][W-1:0]  dy;
    logic [SIZE-1:0][W-1:0]  xhat;
    logic [SIZE-1:0][W-1:0]  expDx;
    logic [W-1:0]            expDgamma;
    logic [W-1:0]            expDbeta;
  } vec_t;

  vec_t vecs[3];

  bn_backward_stream #(.IL(IL), .FL(FL), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_hdr_valid   (hdrValid),
    .o_hdr_ready   (hdrReady),
    .i_hdr_num     (hdrNum),
    .i_hdr_gamma   (hdrGamma),
    .i_hdr_inv_std (hdrInvStd),
    .i_in_valid    (inValid),
    .o_in_ready    (inReady),
    .i_in_dy       (inDy),
    .i_in_xhat     (inXhat),
    .o_out_valid   (outValid),
    .i_out_ready   (outReady),
    .o_out_dx      (outDx),
    .o_out_last    (outLast),
    .o_dgamma      (dgamma),
    .o_dbeta       (dbeta),
    .o_stat_valid  (statValid),
    .o_err_num     (errNum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Present the header and every element of vector v, then wait for EMIT.
  task automatic applyStimulus(input int v);
    int lat;
    @(negedge clk);
    checkOutput($sformatf("%s.hdrReady", vecs[v].name), 32'(hdrReady), 32'(1));
    hdrValid  = 1'b1;
    hdrNum    = NW'(vecs[v].num);
    hdrGamma  = vecs[v].gamma;
    hdrInvStd = vecs[v].invStd;
    @(negedge clk);
    hdrValid = 1'b0;
    for (int i = 0; i < vecs[v].num; i++) begin
      inValid = 1'b1;
      inDy    = vecs[v].dy[i];
      inXhat  = vecs[v].xhat[i];
      @(negedge clk);
    end
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("%s.latency", vecs[v].name), 32'(lat), 32'(2));
  endtask

  // Drain vector v with out_ready held high and compare every element.
  task automatic collectJob(input int v);
    outReady = 1'b1;
    for (int i = 0; i < vecs[v].num; i++) begin
      checkOutput($sformatf("%s.valid%0d", vecs[v].name, i), 32'(outValid), 32'(1));
      checkOutput($sformatf("%s.dx%0d", vecs[v].name, i), 32'(outDx), 32'(vecs[v].expDx[i]));
      checkOutput($sformatf("%s.last%0d", vecs[v].name, i), 32'(outLast),
                  32'(i == vecs[v].num - 1));
      if (i == 0) begin
        checkOutput($sformatf("%s.statValid", vecs[v].name), 32'(statValid), 32'(1));
        checkOutput($sformatf("%s.dgamma", vecs[v].name), 32'(dgamma), 32'(vecs[v].expDgamma));
        checkOutput($sformatf("%s.dbeta", vecs[v].name), 32'(dbeta), 32'(vecs[v].expDbeta));
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s.doneValid", vecs[v].name), 32'(outValid), 32'(0));
    checkOutput($sformatf("%s.doneStat", vecs[v].name), 32'(statValid), 32'(0));
    outReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    reset     = 1'b1;
    hdrValid  = 1'b0;
    hdrNum    = '0;
    hdrGamma  = '0;
    hdrInvStd = '0;
    inValid   = 1'b0;
    inDy      = '0;
    inXhat    = '0;
    outReady  = 1'b0;

    for (int v = 0; v < 3; v++) begin
      vecs[v].dy    = '0;
      vecs[v].xhat  = '0;
      vecs[v].expDx = '0;
    end
    // dY = {2.0, 0}, k = 2.0, kn = 1.0
    vecs[0].name = "diffDy";  vecs[0].num = 2;
    vecs[0].gamma = 20'h10000; vecs[0].invStd = 20'h20000;
    vecs[0].dy[0] = 20'h20000;
    vecs[0].expDx[0] = 20'h20000; vecs[0].expDx[1] = 20'hE0000;
    vecs[0].expDgamma = 20'h00000; vecs[0].expDbeta = 20'h20000;
    // dY = {1, 1}, xhat = {1, -1}: centred gradient cancels
    vecs[1].name = "cancel";  vecs[1].num = 2;
    vecs[1].gamma = 20'h10000; vecs[1].invStd = 20'h10000;
    vecs[1].dy[0] = 20'h10000; vecs[1].dy[1] = 20'h10000;
    vecs[1].xhat[0] = 20'h10000; vecs[1].xhat[1] = 20'hF0000;
    vecs[1].expDgamma = 20'h00000; vecs[1].expDbeta = 20'h20000;
    // 16 x (7.0, 7.0): sums overflow W bits, dX = -22478848 before reduction
    vecs[2].name = "overflow"; vecs[2].num = 16;
    vecs[2].gamma = 20'h10000; vecs[2].invStd = 20'h10000;
    for (int i = 0; i < 16; i++) begin
      vecs[2].dy[i]   = 20'h70000;
      vecs[2].xhat[i] = 20'h70000;
`ifdef BN_BWD_SAT_EN
      vecs[2].expDx[i] = 20'h80000;
`else
      vecs[2].expDx[i] = 20'h90000;
`endif
    end
`ifdef BN_BWD_SAT_EN
    vecs[2].expDgamma = 20'h7FFFF; vecs[2].expDbeta = 20'h7FFFF;
`else
    vecs[2].expDgamma = 20'h00000; vecs[2].expDbeta = 20'h00000;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.hdrReady", 32'(hdrReady), 32'(0));
    checkOutput("rst.inReady", 32'(inReady), 32'(0));
    checkOutput("rst.outValid", 32'(outValid), 32'(0));
    checkOutput("rst.outDx", 32'(outDx), 32'(0));
    checkOutput("rst.statValid", 32'(statValid), 32'(0));
    checkOutput("rst.errNum", 32'(errNum), 32'(0));
    reset = 1'b0;
    #1;
    checkOutput("rst.hdrReadyReleased", 32'(hdrReady), 32'(1));

    // Table-driven jobs
    for (int v = 0; v < 3; v++) begin
      applyStimulus(v);
      collectJob(v);
    end

    // Backpressure: first dX held for three cycles, then both drained
    applyStimulus(0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("bp.valid%0d", c), 32'(outValid), 32'(1));
      checkOutput($sformatf("bp.dx%0d", c), 32'(outDx), 32'(20'h20000));
      checkOutput($sformatf("bp.last%0d", c), 32'(outLast), 32'(0));
      @(negedge clk);
    end
    collectJob(0);

    // Zero-length header is rejected with a single err_num pulse
    hdrValid  = 1'b1;
    hdrNum    = '0;
    hdrGamma  = 20'h10000;
    hdrInvStd = 20'h10000;
    @(posedge clk);
    #1;
    checkOutput("err.pulse", 32'(errNum), 32'(1));
    checkOutput("err.hdrReady", 32'(hdrReady), 32'(1));
    @(negedge clk);
    hdrValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("err.pulseEnds", 32'(errNum), 32'(0));
    checkOutput("err.hdrReadyStill", 32'(hdrReady), 32'(1));
    checkOutput("err.inReady", 32'(inReady), 32'(0));
    checkOutput("err.outValid", 32'(outValid), 32'(0));

    // Oversized header clamps to SIZE beats
    @(negedge clk);
    hdrValid = 1'b1;
    hdrNum   = NW'(20);
    @(negedge clk);
    hdrValid = 1'b0;
    accepted = 0;
    inValid  = 1'b1;
    inDy     = 20'h10000;
    inXhat   = '0;
    for (int c = 0; c < 20; c++) begin
      if (inReady) accepted++;
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("clamp.beats", 32'(accepted), 32'(16));
    outReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("clamp.valid%0d", i), 32'(outValid), 32'(1));
      checkOutput($sformatf("clamp.dx%0d", i), 32'(outDx), 32'(0));
      checkOutput($sformatf("clamp.last%0d", i), 32'(outLast), 32'(i == 15));
`ifdef BN_BWD_SAT_EN
      if (i == 0) checkOutput("clamp.dbeta", 32'(dbeta), 32'(20'h7FFFF));
`else
      if (i == 0) checkOutput("clamp.dbeta", 32'(dbeta), 32'(0));
`endif
      @(negedge clk);
    end
    outReady = 1'b0;
    checkOutput("clamp.doneValid", 32'(outValid), 32'(0));

    // Reset asserted while the second dX is on the output
    applyStimulus(0);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("rstEmit.dx1", 32'(outDx), 32'(20'hE0000));
    checkOutput("rstEmit.last1", 32'(outLast), 32'(1));
    reset = 1'b1;
    #1;
    checkOutput("rstEmit.outValid", 32'(outValid), 32'(0));
    checkOutput("rstEmit.outDx", 32'(outDx), 32'(0));
    checkOutput("rstEmit.outLast", 32'(outLast), 32'(0));
    checkOutput("rstEmit.statValid", 32'(statValid), 32'(0));
    checkOutput("rstEmit.dgamma", 32'(dgamma), 32'(0));
    checkOutput("rstEmit.dbeta", 32'(dbeta), 32'(0));
    checkOutput("rstEmit.inReady", 32'(inReady), 32'(0));
    checkOutput("rstEmit.hdrReady", 32'(hdrReady), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rstEmit.hdrReadyAfter", 32'(hdrReady), 32'(1));
    applyStimulus(1);
    collectJob(1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
